// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the multi-cycle MIPS main control and ALUController.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SRCB_W   = 2;
    localparam int unsigned PCSRC_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_RTWB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_BNE   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b101;

    localparam logic [SRCB_W-1:0] SRCB_REGB    = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SRCB_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

    // Datapath control bundle produced by the output decoder.
    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_a;
        logic [SRCB_W-1:0]  alu_src_b;
        logic [PCSRC_W-1:0] pc_src;
        logic               pc_en;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               reg_write;
        logic               illegal_op;
    } ctrl_t;

    // True for every opcode the control sequences.
    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                          OP_ADDI, OP_ANDI, OP_ORI, OP_J};
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure combinational decode of (state, opcode, zero, mem_ready) into datapath controls.
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e                state_i,
    input  logic [OPCODE_W-1:0]   opcode_i,
    input  logic                  zero_i,
    input  logic                  mem_ready_i,
    output ctrl_t                 ctrl_o
);

    // Per-state control values; everything not named in a state stays 0.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_en     = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = SRCB_IMM_SH2;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.illegal_op = ~is_legal_op(opcode_i);
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_RTEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALUOP_RTYPE;
            end
            S_RTWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                if (opcode_i == OP_BNE) begin
                    ctrl_o.alu_op = ALUOP_BNE;
                    ctrl_o.pc_en  = ~zero_i;
                end else begin
                    ctrl_o.alu_op = ALUOP_BEQ;
                    ctrl_o.pc_en  = zero_i;
                end
            end
            S_IMMEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                if (opcode_i == OP_ANDI)     ctrl_o.alu_op = ALUOP_AND;
                else if (opcode_i == OP_ORI) ctrl_o.alu_op = ALUOP_OR;
                else                         ctrl_o.alu_op = ALUOP_ADD;
            end
            S_IMMWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_src = PCSRC_JUMP;
                ctrl_o.pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control: state register, next-state logic and output gating.
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic [ALUOP_W-1:0]    alu_op,
    output logic                  alu_src_a,
    output logic [SRCB_W-1:0]     alu_src_b,
    output logic [PCSRC_W-1:0]    pc_src,
    output logic                  pc_en,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  illegal_op,
    output logic [STATE_W-1:0]    state
);

    state_e state_q, state_d;
    logic   mem_rdy;
    ctrl_t  ctrl;

    assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

    // State register; reset forces FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state sequencing; any unlisted encoding falls back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_RTYPE:                 state_d = S_RTEXEC;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEXEC;
                    OP_J:                     state_d = S_JUMP;
                    default:                  state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_rdy ? S_FETCH : S_MEMWR;
            S_RTEXEC:  state_d = S_RTWB;
            S_RTWB:    state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_IMMEXEC: state_d = S_IMMWB;
            S_IMMWB:   state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_rdy),
        .ctrl_o      (ctrl)
    );

    // Drive ports; write strobes are held off for the whole time reset is asserted.
    always_comb begin
        alu_op     = ctrl.alu_op;
        alu_src_a  = ctrl.alu_src_a;
        alu_src_b  = ctrl.alu_src_b;
        pc_src     = ctrl.pc_src;
        i_or_d     = ctrl.i_or_d;
        mem_read   = ctrl.mem_read;
        reg_dst    = ctrl.reg_dst;
        mem_to_reg = ctrl.mem_to_reg;
        illegal_op = ctrl.illegal_op;
        pc_en      = ctrl.pc_en     & rst_n;
        mem_write  = ctrl.mem_write & rst_n;
        ir_write   = ctrl.ir_write  & rst_n;
        reg_write  = ctrl.reg_write & rst_n;
        state      = state_q;
    end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle main control FSM; sits directly upstream of ALUController.
- Decodes the 6-bit opcode latched in the instruction register.
- Sequences fetch/decode/execute/memory/writeback, driving all datapath enables and mux selects.
- Produces the 3-bit ALUOp that ALUController consumes alongside func.

Parameters:
- MEM_WAIT, 1, when 1 the FETCH/MEMRD/MEMWR states hold until mem_ready; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26] from instruction register
- zero  input  1  ALU zero flag, valid in BRANCH state
- mem_ready  input  1  memory access complete this cycle
- alu_op  output  3  to ALUController: 000 add, 001 and, 010 or, 011 sub(beq), 100 bne, 101 R-type(func decode)
- alu_src_a  output  1  0=PC, 1=regA
- alu_src_b  output  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
- pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
- pc_en  output  1  PC load enable (resolved)
- i_or_d  output  1  0=PC address, 1=ALUOut address
- mem_read, mem_write, ir_write  output  1 each  memory/IR strobes
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALUOut, 1=MDR
- reg_write  output  1  register file write enable
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- state  output  4  current state, debug

Behaviour:
- States (4-bit encoding in package): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BRANCH, IMMEXEC, IMMWB, JUMP.
- Moore outputs decoded from state only. Exceptions: pc_en uses zero in BRANCH; pc_en uses mem_ready in FETCH.
- Reset (rst_n low, asynchronous): state=FETCH immediately. Once state=FETCH, all strobes (mem_write, reg_write, ir_write, pc_en) are 0 while rst_n is low. illegal_op=0. alu_op=000.
- Reset mid-instruction abandons it with no partial writes after the reset edge.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - Advance to DECODE only when mem_ready=1, else hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 R-type -> RTEXEC
  - 000100 beq / 000101 bne -> BRANCH
  - 001000 addi / 001100 andi / 001101 ori -> IMMEXEC
  - 000010 j -> JUMP
  - other -> FETCH, with illegal_op=1 for this DECODE cycle only
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEMWR: mem_write=1, i_or_d=1. mem_write stays high while waiting. On mem_ready go to FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=101. Next RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, pc_src=01. Next FETCH.
  - beq: alu_op=011, pc_en=zero.
  - bne: alu_op=100, pc_en=~zero.
- IMMEXEC: alu_src_a=1, alu_src_b=10.
  - alu_op = 000 for addi, 001 for andi, 010 for ori. Next IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- JUMP: pc_src=10, pc_en=1. Next FETCH.
- Opcode must stay stable from DECODE through writeback; IR only loads in FETCH.
  - The opcode is re-sampled each state, so the bne/beq and lw/sw distinctions use the live opcode.
- Cycle counts with mem_ready always 1:
  - lw 5
  - sw, R-type, addi/andi/ori 4
  - beq/bne, j 3
  - illegal 2
- Each wait cycle on mem_ready adds 1.
- Unused outputs in a state are 0 (no X).
- An unreachable state encoding recovers to FETCH on the next edge.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum/localparams
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J)
  - ALUOp constants (ALUOP_ADD=000, ALUOP_AND=001, ALUOP_OR=010, ALUOP_BEQ=011, ALUOP_BNE=100, ALUOP_RTYPE=101), also used by ALUController
  - alu_src_b and pc_src select constants
- One natural sub-module: mc_ctrl_outdec, a pure combinational state+opcode -> output decoder. Next-state logic and the state register stay in the top.

Test Plan:
- Reset: hold rst_n=0, then release. Expect state=FETCH, mem_read=1, alu_op=000, reg_write=mem_write=0. Assert rst_n=0 asynchronously mid-MEMWR: mem_write drops with no clock edge needed.
- lw, opcode 100011, mem_ready=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB across 5 cycles. reg_write=1 and mem_to_reg=1 only in cycle 5.
- R-type, opcode 000000: alu_op=101 in RTEXEC, reg_write=1 with reg_dst=1 in RTWB, 4 cycles total. andi 001100 gives alu_op=001 in IMMEXEC; ori gives 010.
- Branches, pc_en in BRANCH:
  - beq, zero=1: pc_en=1, pc_src=01, alu_op=011
  - beq, zero=0: pc_en=0
  - bne, zero=0: pc_en=1, alu_op=100
  - bne, zero=1: pc_en=0
- Memory wait, MEM_WAIT=1: mem_ready=0 for 3 cycles in FETCH, then in MEMRD. State holds, ir_write/pc_en=0 while waiting, lw completes in 11 cycles. Repeat with MEM_WAIT=0: 5 cycles.
- Illegal opcode 111111: illegal_op=1 for exactly the DECODE cycle, return to FETCH, no reg_write/mem_write/pc_en asserted beyond the fetch.
